// File: rtl/vm2002_change_dispenser.sv
// Coin-return dispenser: pays a change amount as quarters/dimes/nickels, greedy, one coin per handshake.
// Latency: first coin_valid two cycles after start, two cycles per coin; coin_ready low stalls ISSUE indefinitely.
module vm2002_change_dispenser #(
    parameter int AMT_W    = 16,
    parameter int TUBE_W   = 8,
    parameter int TUBE_MAX = 200
) (
    input  logic              clk,
    input  logic              hrst,
    input  logic              start,
    input  logic [AMT_W-1:0]  change_amt,
    output logic              busy,
    output logic              coin_valid,
    output logic [1:0]        coin_type,
    input  logic              coin_ready,
    output logic              done,
    output logic              short,
    output logic [AMT_W-1:0]  residual,
    input  logic              refill_valid,
    input  logic [1:0]        refill_coin,
    input  logic [TUBE_W-1:0] refill_count,
    output logic              refill_err,
    output logic [TUBE_W-1:0] nickel_cnt,
    output logic [TUBE_W-1:0] dime_cnt,
    output logic [TUBE_W-1:0] quarter_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_ISSUE, S_FINISH} state_t;

    localparam logic [1:0] C_NONE    = 2'b00;
    localparam logic [1:0] C_NICKEL  = 2'b01;
    localparam logic [1:0] C_DIME    = 2'b10;
    localparam logic [1:0] C_QUARTER = 2'b11;

    localparam logic [TUBE_W:0]  LP_TUBE_MAX = TUBE_MAX[TUBE_W:0];
    localparam logic [AMT_W-1:0] LP_V_NICKEL  = AMT_W'(5);
    localparam logic [AMT_W-1:0] LP_V_DIME    = AMT_W'(10);
    localparam logic [AMT_W-1:0] LP_V_QUARTER = AMT_W'(25);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        w_sel;
    logic              w_busy;
    logic              w_coin_valid;
    logic              w_done;
    logic              w_handshake;

    logic [AMT_W-1:0]  r_remaining;
    logic [AMT_W-1:0]  r_residual;
    logic              r_short;
    logic [1:0]        r_coin_type;
    logic              r_refill_err;
    logic [TUBE_W-1:0] r_nickel;
    logic [TUBE_W-1:0] r_dime;
    logic [TUBE_W-1:0] r_quarter;

    // Widened by one bit so the sum cannot wrap before the clamp.
    function automatic logic [TUBE_W-1:0] sat_add(input logic [TUBE_W-1:0] a,
                                                  input logic [TUBE_W-1:0] b);
        logic [TUBE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > LP_TUBE_MAX) ? LP_TUBE_MAX[TUBE_W-1:0] : s[TUBE_W-1:0];
    endfunction

    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] c);
        case (c)
            C_NICKEL:  return LP_V_NICKEL;
            C_DIME:    return LP_V_DIME;
            C_QUARTER: return LP_V_QUARTER;
            default:   return '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (hrst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sel        = C_NONE;
        w_busy       = 1'b0;
        w_coin_valid = 1'b0;
        w_done       = 1'b0;
        if (r_remaining >= LP_V_QUARTER && r_quarter != '0)
            w_sel = C_QUARTER;
        else if (r_remaining >= LP_V_DIME && r_dime != '0)
            w_sel = C_DIME;
        else if (r_remaining >= LP_V_NICKEL && r_nickel != '0)
            w_sel = C_NICKEL;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_nxt = (change_amt == '0) ? S_FINISH : S_SELECT;
            end
            S_SELECT: begin
                w_busy      = 1'b1;
                w_state_nxt = (w_sel != C_NONE) ? S_ISSUE : S_FINISH;
            end
            S_ISSUE: begin
                w_busy       = 1'b1;
                w_coin_valid = 1'b1;
                if (coin_ready)
                    w_state_nxt = S_SELECT;
            end
            S_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_handshake = w_coin_valid && coin_ready;

    always_ff @(posedge clk) begin
        if (hrst) begin
            r_remaining  <= '0;
            r_residual   <= '0;
            r_short      <= 1'b0;
            r_coin_type  <= C_NONE;
            r_refill_err <= 1'b0;
            r_nickel     <= '0;
            r_dime       <= '0;
            r_quarter    <= '0;
        end else begin
            r_refill_err <= refill_valid && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (refill_valid) begin
                        case (refill_coin)
                            C_NICKEL:  r_nickel  <= sat_add(r_nickel, refill_count);
                            C_DIME:    r_dime    <= sat_add(r_dime, refill_count);
                            C_QUARTER: r_quarter <= sat_add(r_quarter, refill_count);
                            default: ;
                        endcase
                    end
                    if (start) begin
                        r_remaining <= change_amt;
                        r_short     <= 1'b0;
                        r_residual  <= '0;
                    end
                end
                S_SELECT: begin
                    if (w_sel != C_NONE) begin
                        r_coin_type <= w_sel;
                    end else begin
                        r_short    <= (r_remaining != '0);
                        r_residual <= r_remaining;
                    end
                end
                S_ISSUE: begin
                    if (w_handshake) begin
                        r_coin_type <= C_NONE;
                        r_remaining <= r_remaining - coin_value(r_coin_type);
                        case (r_coin_type)
                            C_NICKEL:  r_nickel  <= r_nickel - 1'b1;
                            C_DIME:    r_dime    <= r_dime - 1'b1;
                            C_QUARTER: r_quarter <= r_quarter - 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = w_busy;
    assign coin_valid  = w_coin_valid;
    assign coin_type   = r_coin_type;
    assign done        = w_done;
    assign short       = r_short;
    assign residual    = r_residual;
    assign refill_err  = r_refill_err;
    assign nickel_cnt  = r_nickel;
    assign dime_cnt    = r_dime;
    assign quarter_cnt = r_quarter;

endmodule
